// File: rtl/stream_drv_pkg.sv
// stream_drv_pkg: shared FSM state enum, count width, default geometry and saturating increment
package stream_drv_pkg;
  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT_RES, DONE} state_t;
  localparam int CNT_W = 16;
  localparam int DEF_WIDTH = 255;
  localparam int DEF_ARITY = 3;
  localparam int DEF_DEPTH = 128;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/stream_drv_mem.sv
// stream_drv_mem: element buffer, single-port write, registered read (clk, reset, we/waddr/wdata, re/raddr, rdata)
module stream_drv_mem import stream_drv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ENTRIES = DEF_DEPTH * DEF_ARITY,
  parameter int AW = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [ENTRIES];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/stream_packet_driver.sv
// stream_packet_driver: replays loaded packets on m_*, collects results on s_*, echoes them on res_*, with busy/done/err status
module stream_packet_driver import stream_drv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ARITY = DEF_ARITY,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_clear,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      cfg_pkt_num,
  input  logic [3:0]       cfg_gap,
  input  logic             cfg_loop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [WIDTH-1:0] m_payload,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_payload,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic             err_unexpected,
  output logic [15:0]      sent_count,
  output logic [15:0]      res_count
);
  localparam int ENT = DEPTH * ARITY;
  localparam int PW = $clog2(ENT + 1);
  localparam logic [PW-1:0] FULL = PW'(ENT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ARITY - 1);
  localparam logic ONE_BEAT = ARITY == 1;
  state_t state;
  logic [PW-1:0] wptr, rptr, raddr;
  logic [CNT_W-1:0] lp_idx, lp_cnt, idx, pkt, n_pkt, n_avail;
  logic [3:0] gap_cnt;
  logic stop_req, idle_like, wr, go, hs, pkt_end, final_pkt, halt, re, pkt_fill;
  assign busy = state == SEND || state == GAP || state == WAIT_RES;
  assign done = state == DONE;
  assign s_ready = busy;
  assign idle_like = state == IDLE || state == DONE;
  assign load_ready = !busy && wptr != FULL;
  assign wr = idle_like && load_valid && load_ready && !load_clear;
  assign pkt_fill = lp_idx == LAST_IDX;
  assign go = idle_like && start;
  assign n_avail = (cfg_pkt_num < lp_cnt) ? cfg_pkt_num : lp_cnt;
  assign hs = m_valid && m_ready;
  assign pkt_end = hs && m_last;
  assign final_pkt = (pkt + CNT_W'(1)) == n_pkt;
  assign halt = stop_req || stop;
  // the read address always points at the beat that will be presented next, so m_payload is ready when m_valid rises
  assign raddr = (go || (pkt_end && final_pkt)) ? '0 : rptr + PW'(1);
  assign re = go || hs;
  stream_drv_mem #(.WIDTH(WIDTH), .ENTRIES(ENT), .AW(PW)) u_mem (
    .clk(clk), .reset(reset), .we(wr), .waddr(wptr), .wdata(load_data),
    .re(re), .raddr(raddr), .rdata(m_payload)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      err_unexpected <= 1'b0;
      sent_count <= '0;
      res_count <= '0;
      wptr <= '0;
      rptr <= '0;
      lp_idx <= '0;
      lp_cnt <= '0;
      idx <= '0;
      pkt <= '0;
      n_pkt <= '0;
      gap_cnt <= '0;
      stop_req <= 1'b0;
    end else begin
      res_valid <= s_valid && s_ready;
      if (s_valid && s_ready) begin
        res_data <= s_payload;
        if (res_count < sent_count) res_count <= sat_inc(res_count);
        else err_unexpected <= 1'b1;
      end
      if (idle_like && load_clear) begin
        wptr <= '0;
        lp_idx <= '0;
        lp_cnt <= '0;
      end else if (wr) begin
        wptr <= wptr + PW'(1);
        lp_idx <= pkt_fill ? '0 : lp_idx + CNT_W'(1);
        if (pkt_fill) lp_cnt <= sat_inc(lp_cnt);
      end
      case (state)
        IDLE, DONE:
          if (start) begin
            n_pkt <= n_avail;
            sent_count <= '0;
            res_count <= '0;
            err_unexpected <= 1'b0;
            stop_req <= 1'b0;
            pkt <= '0;
            idx <= '0;
            rptr <= '0;
            state <= (n_avail == '0) ? DONE : SEND;
            m_valid <= n_avail != '0;
            m_last <= (n_avail != '0) && ONE_BEAT;
          end
        SEND: begin
          if (stop) stop_req <= 1'b1;
          if (hs) begin
            rptr <= raddr;
            if (m_last) begin
              sent_count <= sat_inc(sent_count);
              idx <= '0;
              m_last <= ONE_BEAT;
              pkt <= final_pkt ? '0 : pkt + CNT_W'(1);
              if (halt || (final_pkt && !cfg_loop)) begin
                state <= WAIT_RES;
                m_valid <= 1'b0;
                m_last <= 1'b0;
              end else if (cfg_gap != '0) begin
                state <= GAP;
                gap_cnt <= cfg_gap;
                m_valid <= 1'b0;
              end
            end else begin
              idx <= idx + CNT_W'(1);
              m_last <= (idx + CNT_W'(1)) == LAST_IDX;
            end
          end
        end
        GAP:
          if (stop) state <= WAIT_RES;
          else if (gap_cnt == 4'd1) begin
            state <= SEND;
            m_valid <= 1'b1;
          end else gap_cnt <= gap_cnt - 4'd1;
        WAIT_RES:
          if (res_count == sent_count) state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule
